// File: rtl/round_controller.sv
// Game-round sequencer: idle, 3-2-1 ready countdown, play, pause and game over.
// Drives the timer's go/restart controls, the HUD countdown digit and a round-end strobe.
module round_controller #(
  parameter logic [7:0] SEC_FRAMES       = 8'd60,
  parameter logic [7:0] OVER_LOCK_FRAMES = 8'd120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [7:0] time_left,
  output logic [2:0] state,
  output logic       timer_go,
  output logic       timer_restart,
  output logic [1:0] countdown,
  output logic       game_over
);

  localparam int unsigned FCNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            next_state;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] next_fcnt;
  logic [1:0]        next_cd;
  logic              next_go;
  logic              next_restart;
  logic              next_over;
  logic              start_prev;
  logic              pause_prev;
  logic              start_edge;
  logic              pause_edge;
  logic              sec_done;

  assign start_edge = start_btn & ~start_prev;
  assign pause_edge = pause_btn & ~pause_prev;
  assign sec_done   = frame_tick && (fcnt == SEC_FRAMES - 8'd1);
  assign state      = state_q;

  // Previous-value flops reset high so a button held through reset is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
    end
  end

  // State, frame counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fcnt          <= '0;
      countdown     <= 2'd0;
      timer_go      <= 1'b0;
      timer_restart <= 1'b1;
      game_over     <= 1'b0;
    end else begin
      state_q       <= next_state;
      fcnt          <= next_fcnt;
      countdown     <= next_cd;
      timer_go      <= next_go;
      timer_restart <= next_restart;
      game_over     <= next_over;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    next_state = state_q;
    next_cd    = countdown;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          next_state = READY;
          next_cd    = 2'd3;
        end
      end
      READY: begin
        if (sec_done) begin
          if (countdown == 2'd1) begin
            next_state = PLAY;
            next_cd    = 2'd0;
          end else begin
            next_cd = countdown - 2'd1;
          end
        end
      end
      PLAY: begin
        if (time_left == 8'd0) begin
          next_state = OVER;
        end else if (pause_edge) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (start_edge) begin
          next_state = IDLE;
        end else if (pause_edge) begin
          next_state = PLAY;
        end
      end
      OVER: begin
        // Early start presses are dropped, not remembered.
        if (start_edge && (fcnt >= OVER_LOCK_FRAMES)) begin
          next_state = READY;
          next_cd    = 2'd3;
        end
      end
      default: next_state = IDLE;
    endcase

    if (next_state != READY) begin
      next_cd = 2'd0;
    end

    next_fcnt = fcnt;
    if ((next_state != state_q) || ((state_q == READY) && sec_done)) begin
      next_fcnt = '0;
    end else if (frame_tick && (fcnt != 8'hFF)) begin
      next_fcnt = fcnt + 8'd1;
    end

    next_go      = (next_state == PLAY);
    next_restart = (next_state == IDLE) || (next_state == READY);
    next_over    = (state_q == PLAY) && (next_state == OVER);
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with expected outputs queued per step
// and popped against the DUT once the step's clock edge has happened.
module tb_round_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic       pause_btn;
  logic [7:0] time_left;
  logic [2:0] state;
  logic       timer_go;
  logic       timer_restart;
  logic [1:0] countdown;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  round_controller #(
    .SEC_FRAMES      (8'd4),
    .OVER_LOCK_FRAMES(8'd5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .time_left    (time_left),
    .state        (state),
    .timer_go     (timer_go),
    .timer_restart(timer_restart),
    .countdown    (countdown),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, leaving time 1 unit past the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Queue the expected {state, timer_go, timer_restart, countdown, game_over}.
  task automatic expect_out(input string tag, input logic [2:0] s, input logic g,
                            input logic r, input logic [1:0] c, input logic o);
    exp_q.push_back({s, g, r, c, o});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [7:0] obs;
    logic [7:0] exp;
    string      tag;
    obs = {state, timer_go, timer_restart, countdown, game_over};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed={st=%0d go=%b rst=%b cd=%0d ov=%b} expected={st=%0d go=%b rst=%b cd=%0d ov=%b}",
               tag, obs[7:5], obs[4], obs[3], obs[2:1], obs[0],
               exp[7:5], exp[4], exp[3], exp[2:1], exp[0]);
      end
    end
  endtask

  // Twelve frame ticks with idle cycles in between, taking READY into PLAY.
  task automatic run_ready();
    for (int i = 0; i < 12; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    pause_btn  = 1'b0;
    time_left  = 8'd30;

    #2;
    expect_out("reset_state", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();

    @(negedge clock);
    reset = 1'b0;
    cyc(2);
    expect_out("idle_after_reset", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();

    // Pause in IDLE is ignored.
    pause_btn = 1'b1;
    cyc(1);
    expect_out("idle_pause_ignored", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();
    pause_btn = 1'b0;
    cyc(1);

    start_btn = 1'b1;
    cyc(1);
    expect_out("idle_to_ready", S_READY, 1'b0, 1'b1, 2'd3, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);

    // Countdown digit seen while each of the 12 ticks is present.
    for (int i = 0; i < 12; i++) begin
      frame_tick = 1'b1;
      expect_out($sformatf("countdown_tick%0d", i + 1), S_READY, 1'b0, 1'b1,
                 2'(3 - i / 4), 1'b0);
      check_out();
      cyc(1);
      frame_tick = 1'b0;
      if (i == 10) begin
        expect_out("ready_after_11_ticks", S_READY, 1'b0, 1'b1, 2'd1, 1'b0);
        check_out();
      end
      if (i < 11) cyc(1);
    end
    expect_out("play_after_12_ticks", S_PLAY, 1'b1, 1'b0, 2'd0, 1'b0);
    check_out();

    // Pause, hold, resume, pause again, then abort with both buttons.
    pause_btn = 1'b1;
    cyc(1);
    expect_out("play_to_pause", S_PAUSE, 1'b0, 1'b0, 2'd0, 1'b0);
    check_out();
    pause_btn = 1'b0;
    cyc(1);
    expect_out("pause_hold", S_PAUSE, 1'b0, 1'b0, 2'd0, 1'b0);
    check_out();
    pause_btn = 1'b1;
    cyc(1);
    expect_out("pause_to_play", S_PLAY, 1'b1, 1'b0, 2'd0, 1'b0);
    check_out();
    pause_btn = 1'b0;
    cyc(1);
    pause_btn = 1'b1;
    cyc(1);
    expect_out("play_to_pause_2", S_PAUSE, 1'b0, 1'b0, 2'd0, 1'b0);
    check_out();
    pause_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    pause_btn = 1'b1;
    cyc(1);
    expect_out("pause_abort_to_idle", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    cyc(1);

    // Back into PLAY, start is ignored there.
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(1);
    run_ready();
    expect_out("play_again", S_PLAY, 1'b1, 1'b0, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b1;
    cyc(1);
    expect_out("play_start_ignored", S_PLAY, 1'b1, 1'b0, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);

    // Time-out beats a simultaneous pause edge; strobe lasts one cycle.
    time_left = 8'd0;
    pause_btn = 1'b1;
    cyc(1);
    expect_out("game_over_entry", S_OVER, 1'b0, 1'b0, 2'd0, 1'b1);
    check_out();
    pause_btn = 1'b0;
    cyc(1);
    expect_out("game_over_strobe_end", S_OVER, 1'b0, 1'b0, 2'd0, 1'b0);
    check_out();

    // Lockout: start after 3 ticks dropped, after 5 ticks accepted.
    ticks(3);
    start_btn = 1'b1;
    cyc(1);
    expect_out("over_locked_start", S_OVER, 1'b0, 1'b0, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);
    ticks(2);
    time_left = 8'd30;
    start_btn = 1'b1;
    cyc(1);
    expect_out("over_to_ready", S_READY, 1'b0, 1'b1, 2'd3, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);

    // Reset mid-PLAY with start held.
    run_ready();
    expect_out("play_before_reset", S_PLAY, 1'b1, 1'b0, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b1;
    cyc(1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset_mid_play", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();
    @(negedge clock);
    reset = 1'b0;
    cyc(3);
    expect_out("held_start_no_edge", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);
    expect_out("start_released", S_IDLE, 1'b0, 1'b1, 2'd0, 1'b0);
    check_out();
    start_btn = 1'b1;
    cyc(1);
    expect_out("start_repressed", S_READY, 1'b0, 1'b1, 2'd3, 1'b0);
    check_out();
    start_btn = 1'b0;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
